// File: rtl/chan_accum_pkg.sv
// Shared types and the width-generic arithmetic helper for the channel accumulator.
package chan_accum_pkg;

    localparam int DEFAULT_WIDTH = 8;
    // Widest datapath apply_op can serve; callers use WIDTH < MAXW.
    localparam int MAXW = 32;

    typedef enum logic [1:0] {
        OP_SUM  = 2'd0,
        OP_DBL  = 2'd1,
        OP_LOAD = 2'd2,
        OP_CLR  = 2'd3
    } op_t;

    // Returns {sat, result}. Operands must already be zero-extended from
    // 'width' bits. The raw sum needs two guard bits (acc + x + y or acc + 2x).
    function automatic logic [MAXW:0] apply_op(
        input logic [MAXW-1:0] acc,
        input logic [MAXW-1:0] x,
        input logic [MAXW-1:0] y,
        input op_t             op,
        input int              width,
        input logic            sat_en
    );
        logic [MAXW+1:0] raw;
        logic [MAXW-1:0] mask;
        logic [MAXW-1:0] res;
        logic            sat;
        mask = {MAXW{1'b1}} >> (MAXW - width);
        case (op)
            OP_SUM:  raw = {2'b00, acc} + {2'b00, x} + {2'b00, y};
            OP_DBL:  raw = {2'b00, acc} + {1'b0, x, 1'b0};
            OP_LOAD: raw = {2'b00, x};
            default: raw = '0;
        endcase
        if (sat_en) begin
            sat = (raw > {2'b00, mask});
            res = sat ? mask : raw[MAXW-1:0];
        end else begin
            sat = ((raw >> width) != '0);
            res = raw[MAXW-1:0] & mask;
        end
        return {sat, res};
    endfunction

endpackage

// File: rtl/chan_accum_rr_arb.sv
// Round-robin arbiter: first requester at or above ptr, wrapping N-1 -> 0.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx
);

    int   cand;
    logic found;

    // gnt_idx reports the winner even when en is low; gnt is gated by en.
    always_comb begin
        cand    = 0;
        found   = 1'b0;
        gnt     = '0;
        gnt_idx = '0;
        for (int i = 0; i < N; i++) begin
            cand = (int'(ptr) + i) % N;
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt_idx   = PW'(cand);
                gnt[cand] = en;
            end
        end
    end

endmodule

// File: rtl/chan_accum_rr.sv
// Multi-channel accumulator: round-robin grant, one shared adder, registered output.
module chan_accum_rr
    import chan_accum_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int NCH   = 4,
    parameter int SAT   = 1,
    parameter int CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NCH-1:0]     in_valid,
    output logic [NCH-1:0]     in_ready,
    input  logic [NCH*WIDTH-1:0] in_x,
    input  logic [NCH*WIDTH-1:0] in_y,
    input  logic [NCH*2-1:0]   in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CW-1:0]      out_chan,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_sat
);

    // Handshake: a beat moves when valid && ready on the same rising edge.
    // The output register accepts a new result only when empty or being
    // popped that edge; otherwise out_* hold and every in_ready stays low.

    logic [WIDTH-1:0] acc [NCH];
    logic [CW-1:0]    ptr;
    logic [CW-1:0]    ptr_nxt;
    logic [CW-1:0]    gnt_idx;
    logic [NCH-1:0]   gnt;
    logic             free;
    logic             xfer;
    logic [WIDTH-1:0] sel_acc;
    logic [WIDTH-1:0] sel_x;
    logic [WIDTH-1:0] sel_y;
    op_t              sel_op;
    logic [MAXW:0]    op_out;
    logic [WIDTH-1:0] op_res;
    logic             op_sat;
    logic             op_unused;

    assign free = !out_valid || out_ready;

    rr_arbiter #(
        .N  (NCH),
        .PW (CW)
    ) u_arb (
        .req     (in_valid),
        .ptr     (ptr),
        .en      (free && rst_n),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign in_ready = gnt;
    assign xfer     = |(in_valid & in_ready);

    assign sel_acc = acc[gnt_idx];
    assign sel_x   = in_x[gnt_idx*WIDTH +: WIDTH];
    assign sel_y   = in_y[gnt_idx*WIDTH +: WIDTH];
    assign sel_op  = op_t'(in_mode[gnt_idx*2 +: 2]);

    assign op_out    = apply_op(MAXW'(sel_acc), MAXW'(sel_x), MAXW'(sel_y),
                                sel_op, WIDTH, SAT != 0);
    assign op_res    = op_out[WIDTH-1:0];
    assign op_sat    = op_out[MAXW];
    assign op_unused = ^op_out[MAXW-1:WIDTH];

    assign ptr_nxt = (gnt_idx == CW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_chan  <= '0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            ptr       <= '0;
            for (int i = 0; i < NCH; i++) begin
                acc[i] <= '0;
            end
        end else if (xfer) begin
            out_valid    <= 1'b1;
            out_chan     <= gnt_idx;
            out_data     <= op_res;
            out_sat      <= op_sat;
            acc[gnt_idx] <= op_res;
            ptr          <= ptr_nxt;
        end else if (out_ready) begin
            // Pop with nothing to replace it; out_data keeps its last value.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_chan_accum_rr.sv
// Bench for chan_accum_rr: a saturating and a wrapping instance share stimulus.
module tb_chan_accum_rr;
    import chan_accum_pkg::*;

    localparam int W   = 8;
    localparam int NCH = 4;
    localparam int CW  = 2;
    localparam int MAXV = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic [NCH-1:0]   in_valid;
    logic [NCH*W-1:0] in_x, in_y;
    logic [2*NCH-1:0] in_mode;
    logic             out_ready;

    logic [NCH-1:0] rdy_s, rdy_w;
    logic           ov_s, ov_w, sat_s, sat_w;
    logic [CW-1:0]  ch_s, ch_w;
    logic [W-1:0]   d_s, d_w;

    always #5 clk = ~clk;

    chan_accum_rr #(.WIDTH(W), .NCH(NCH), .SAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_s),
        .in_x(in_x), .in_y(in_y), .in_mode(in_mode), .out_valid(ov_s),
        .out_ready(out_ready), .out_chan(ch_s), .out_data(d_s), .out_sat(sat_s)
    );

    chan_accum_rr #(.WIDTH(W), .NCH(NCH), .SAT(0)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_w),
        .in_x(in_x), .in_y(in_y), .in_mode(in_mode), .out_valid(ov_w),
        .out_ready(out_ready), .out_chan(ch_w), .out_data(d_w), .out_sat(sat_w)
    );

    // Reference model: index 0 saturating, index 1 wrapping.
    int m_acc [2][NCH];
    int m_data [2];
    bit m_sat [2];
    int m_ptr  = 0;
    bit m_ov   = 1'b0;
    int m_chan = 0;
    int mg, mraw, mx, my, mop;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int pick();
        for (int k = 0; k < NCH; k++) begin
            if (in_valid[(m_ptr + k) % NCH]) return (m_ptr + k) % NCH;
        end
        return -1;
    endfunction

    function automatic logic [31:0] exp_ready();
        int g;
        if (!rst_n || !(!m_ov || out_ready)) return 0;
        g = pick();
        return (g < 0) ? 0 : (32'd1 << g);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_ptr = 0; m_ov = 1'b0; m_chan = 0;
            for (int s = 0; s < 2; s++) begin
                m_data[s] = 0; m_sat[s] = 1'b0;
                for (int c = 0; c < NCH; c++) m_acc[s][c] = 0;
            end
        end else begin
            mg = pick();
            if ((!m_ov || out_ready) && mg >= 0) begin
                mop = int'(in_mode[mg*2 +: 2]);
                mx  = int'(in_x[mg*W +: W]);
                my  = int'(in_y[mg*W +: W]);
                for (int s = 0; s < 2; s++) begin
                    case (mop)
                        0: mraw = m_acc[s][mg] + mx + my;
                        1: mraw = m_acc[s][mg] + 2 * mx;
                        2: mraw = mx;
                        default: mraw = 0;
                    endcase
                    if (s == 0) m_data[s] = (mraw > MAXV) ? MAXV : mraw;
                    else        m_data[s] = mraw % (MAXV + 1);
                    m_sat[s] = (mraw > MAXV);
                    m_acc[s][mg] = m_data[s];
                end
                m_ov = 1'b1; m_chan = mg; m_ptr = (mg + 1) % NCH;
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready_sat", rdy_s, exp_ready());
        chk("in_ready_wrap", rdy_w, exp_ready());
        chk("out_valid_sat", ov_s, m_ov);
        chk("out_valid_wrap", ov_w, m_ov);
        chk("out_chan_sat", ch_s, m_chan);
        chk("out_chan_wrap", ch_w, m_chan);
        chk("out_data_sat", d_s, m_data[0]);
        chk("out_data_wrap", d_w, m_data[1]);
        chk("out_sat_sat", sat_s, m_sat[0]);
        chk("out_sat_wrap", sat_w, m_sat[1]);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input op_t op, input int x, input int y);
        in_x[c*W +: W]    = W'(x);
        in_y[c*W +: W]    = W'(y);
        in_mode[c*2 +: 2] = op;
    endtask

    task automatic send(input int c, input op_t op, input int x, input int y);
        in_valid    = '0;
        in_valid[c] = 1'b1;
        set_ch(c, op, x, y);
        out_ready   = 1'b1;
        step();
        in_valid    = '0;
    endtask

    initial begin
        rst_n = 1'b0; out_ready = 1'b1; in_valid = '1; in_y = '0; in_x = '0; in_mode = '0;
        for (int i = 0; i < NCH; i++) set_ch(i, OP_LOAD, 10 * (i + 1), 0);
        repeat (3) step();
        chk("rst_in_ready", rdy_s, 0);
        chk("rst_out_valid", ov_s, 0);
        rst_n = 1'b1;
        #1;
        chk("first_grant", rdy_s, 4'b0001);
        step();
        in_valid = '0;
        chk("first_chan", ch_s, 0);
        chk("first_data", d_s, 10);

        // Saturation on channel 1
        send(1, OP_LOAD, 200, 0);
        chk("load_data", d_s, 200); chk("load_sat", sat_s, 0);
        send(1, OP_SUM, 40, 20);
        chk("sum_sat_data", d_s, 255); chk("sum_sat_flag", sat_s, 1);
        send(1, OP_CLR, 0, 0);
        chk("clr_data", d_s, 0);

        // Wrap on channel 2
        send(2, OP_LOAD, 250, 0);
        send(2, OP_DBL, 5, 99);
        chk("dbl_wrap_data", d_w, 4); chk("dbl_wrap_carry", sat_w, 1);
        chk("dbl_sat_data", d_s, 255);
        send(2, OP_SUM, 1, 1);
        chk("sum_wrap_data", d_w, 6); chk("sum_wrap_carry", sat_w, 0);

        // Round robin, pointer brought to 0 first
        send(3, OP_LOAD, 7, 0);
        in_valid = '1;
        for (int i = 0; i < NCH; i++) set_ch(i, OP_SUM, 1, 0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("rr_chan", ch_s, i % 4);
            chk("rr_valid", ov_s, 1);
        end

        // Backpressure with all channels requesting
        out_ready = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_in_ready", rdy_s, 0);
            chk("bp_valid", ov_s, 1);
            chk("bp_chan", ch_s, 3);
            chk("bp_data", d_s, 9);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_grant", rdy_s, 4'b0001);
        step();
        in_valid = '0;
        chk("bp_next_chan", ch_s, 0);
        chk("bp_next_data", d_s, 13);

        // Reset while a result is stalled
        out_ready = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        chk("midrst_valid_sat", ov_s, 0);
        chk("midrst_valid_wrap", ov_w, 0);
        chk("midrst_data", d_s, 0);
        rst_n = 1'b1;
        send(3, OP_SUM, 3, 4);
        chk("post_rst_data", d_s, 7); chk("post_rst_chan", ch_s, 3);
        send(0, OP_SUM, 0, 0);
        chk("post_rst_acc0", d_s, 0); chk("post_rst_chan0", ch_s, 0);

        repeat (2) step();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
